// File: rtl/vga_frame_timer_if.sv
// Raster and board-tile scan bundle from the frame timer to the pixel colour generator.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer samples on pix_en and cannot stall the scan.
interface vga_frame_timer_if #(
    parameter int CW  = 10,
    parameter int TCW = 3,
    parameter int TRW = 3,
    parameter int PXW = 6,
    parameter int PYW = 6
);
    logic           pix_en;
    logic           hsync;
    logic           vsync;
    logic           sync_b;
    logic           blank_b;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           frame_start;
    logic           line_start;
    logic           in_board;
    logic [TCW-1:0] tile_col;
    logic [TRW-1:0] tile_row;
    logic [PXW-1:0] tile_px;
    logic [PYW-1:0] tile_py;

    modport master (
        output pix_en, hsync, vsync, sync_b, blank_b, x, y,
               frame_start, line_start, in_board,
               tile_col, tile_row, tile_px, tile_py
    );

    modport slave (
        input  pix_en, hsync, vsync, sync_b, blank_b, x, y,
               frame_start, line_start, in_board,
               tile_col, tile_row, tile_px, tile_py
    );
endinterface

// File: rtl/vga_frame_timer.sv
// VGA sync/blank/raster generator with incrementally tracked board tile row/col/offset.
// Latency: 0 strobes; every output describes the pixel presented with pix_en.
// Backpressure: none; free-running from clk, only rst stops the scan.
module vga_frame_timer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10,
    parameter int TILES_X  = 8,
    parameter int TILES_Y  = 8,
    parameter int TILE_W   = 60,
    parameter int TILE_H   = 60,
    parameter int BOARD_X0 = 80,
    parameter int BOARD_Y0 = 0
) (
    input  logic clk,
    input  logic rst,
    vga_frame_timer_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int BX_END  = BOARD_X0 + TILES_X * TILE_W;
    localparam int BY_END  = BOARD_Y0 + TILES_Y * TILE_H;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TCW     = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TRW     = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int PXW     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int PYW     = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    // Refuse configurations whose board or counters cannot fit.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_frame_timer: CLK_DIV must be at least 1");
    end
    if (BX_END > H_ACTIVE) begin : g_bad_board_x
        $error("vga_frame_timer: board extends past the active width");
    end
    if (BY_END > V_ACTIVE) begin : g_bad_board_y
        $error("vga_frame_timer: board extends past the active height");
    end
    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
        $error("vga_frame_timer: CW too small for the line/frame totals");
    end

    logic [DW-1:0]  div;
    logic           stb;
    logic [CW-1:0]  h, v, h_nxt, v_nxt;
    logic           h_wrap;
    int             hn, vn;
    logic [PXW-1:0] tpx, tpx_nxt;
    logic [PYW-1:0] tpy, tpy_nxt;
    logic [TCW-1:0] tcol, tcol_nxt;
    logic [TRW-1:0] trow, trow_nxt;
    logic           hs_nxt, vs_nxt, blank_nxt, inb_nxt;

    assign stb    = (div == DW'(CLK_DIV - 1));
    assign h_wrap = (h == CW'(H_TOTAL - 1));
    assign hn     = int'(h_nxt);
    assign vn     = int'(v_nxt);

    // Composite sync is not used by the display path.
    assign vid.sync_b = 1'b1;

    // Next raster position and the decoded levels that go with it.
    always_comb begin
        h_nxt = h_wrap ? '0 : h + 1'b1;
        v_nxt = v;
        if (h_wrap) begin
            v_nxt = (v == CW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end
        hs_nxt    = (hn >= HS_BEG && hn < HS_END) ? SYNC_POL : !SYNC_POL;
        vs_nxt    = (vn >= VS_BEG && vn < VS_END) ? SYNC_POL : !SYNC_POL;
        blank_nxt = (hn < H_ACTIVE) && (vn < V_ACTIVE);
        inb_nxt   = (hn >= BOARD_X0) && (hn < BX_END) &&
                    (vn >= BOARD_Y0) && (vn < BY_END);
    end

    // Tile counters restart at the board edge and step with the scan, so no divider is needed.
    always_comb begin
        tpx_nxt  = tpx + 1'b1;
        tcol_nxt = tcol;
        if (h_nxt == CW'(BOARD_X0)) begin
            tpx_nxt  = '0;
            tcol_nxt = '0;
        end else if (tpx == PXW'(TILE_W - 1)) begin
            tpx_nxt  = '0;
            tcol_nxt = tcol + 1'b1;
        end
        tpy_nxt  = tpy;
        trow_nxt = trow;
        if (h_wrap) begin
            if (v_nxt == CW'(BOARD_Y0)) begin
                tpy_nxt  = '0;
                trow_nxt = '0;
            end else if (tpy == PYW'(TILE_H - 1)) begin
                tpy_nxt  = '0;
                trow_nxt = trow + 1'b1;
            end else begin
                tpy_nxt  = tpy + 1'b1;
            end
        end
    end

    // Pixel-enable divider: counts 0..CLK_DIV-1, strobe on the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= stb ? '0 : div + 1'b1;
        end
    end

    // Scan position; reset parks on the last pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h    <= CW'(H_TOTAL - 1);
            v    <= CW'(V_TOTAL - 1);
            tpx  <= '0;
            tpy  <= '0;
            tcol <= '0;
            trow <= '0;
        end else if (stb) begin
            h    <= h_nxt;
            v    <= v_nxt;
            tpx  <= tpx_nxt;
            tpy  <= tpy_nxt;
            tcol <= tcol_nxt;
            trow <= trow_nxt;
        end
    end

    // All outputs load together on the strobe edge so they carry zero skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.pix_en      <= 1'b0;
            vid.hsync       <= !SYNC_POL;
            vid.vsync       <= !SYNC_POL;
            vid.blank_b     <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.in_board    <= 1'b0;
            vid.tile_col    <= '0;
            vid.tile_row    <= '0;
            vid.tile_px     <= '0;
            vid.tile_py     <= '0;
        end else begin
            vid.pix_en <= stb;
            if (stb) begin
                vid.hsync       <= hs_nxt;
                vid.vsync       <= vs_nxt;
                vid.blank_b     <= blank_nxt;
                vid.x           <= h_nxt;
                vid.y           <= v_nxt;
                vid.frame_start <= (h_nxt == '0) && (v_nxt == '0);
                vid.line_start  <= (h_nxt == '0);
                vid.in_board    <= inb_nxt;
                vid.tile_col    <= inb_nxt ? tcol_nxt : '0;
                vid.tile_row    <= inb_nxt ? trow_nxt : '0;
                vid.tile_px     <= inb_nxt ? tpx_nxt  : '0;
                vid.tile_py     <= inb_nxt ? tpy_nxt  : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer: default 640x480 instance plus a tiny alternate instance.
// Latency: checks outputs one time unit after every clk edge against an arithmetic model.
// Backpressure: none; the DUTs free-run, only rst is driven.
module tb_vga_frame_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        int div, pol, tx, ty, tw, th, bx, by;
    } cfg_t;

    typedef struct packed {
        logic       pix_en, hsync, vsync, sync_b, blank_b;
        logic [9:0] x, y;
        logic       frame_start, line_start, in_board;
        logic [7:0] tc, tr, tpx, tpy;
    } obs_t;

    localparam cfg_t CFG_A = '{ha: 640, hfp: 16, hs: 96, hbp: 48,
                               va: 480, vfp: 10, vs: 2, vbp: 33,
                               div: 2, pol: 0, tx: 8, ty: 8, tw: 60, th: 60, bx: 80, by: 0};
    localparam cfg_t CFG_B = '{ha: 8, hfp: 2, hs: 2, hbp: 2,
                               va: 4, vfp: 1, vs: 1, vbp: 1,
                               div: 1, pol: 1, tx: 2, ty: 2, tw: 4, th: 2, bx: 0, by: 0};

    vga_frame_timer_if #(.CW(10), .TCW(3), .TRW(3), .PXW(6), .PYW(6)) ia ();
    vga_frame_timer_if #(.CW(4),  .TCW(1), .TRW(1), .PXW(2), .PYW(1)) ib ();

    vga_frame_timer dut_a (
        .clk (clk),
        .rst (rst),
        .vid (ia)
    );

    vga_frame_timer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1), .CW(4),
        .TILES_X(2), .TILES_Y(2), .TILE_W(4), .TILE_H(2),
        .BOARD_X0(0), .BOARD_Y0(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vid (ib)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs k clk edges after the last edge that saw rst high.
    function automatic obs_t model(input cfg_t c, input int k);
        obs_t o;
        int   n, ht, vt, xx, yy;
        o        = '0;
        o.sync_b = 1'b1;
        o.hsync  = !c.pol[0];
        o.vsync  = !c.pol[0];
        if (k < c.div) return o;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        n  = k / c.div - 1;
        xx = n % ht;
        yy = (n / ht) % vt;
        o.pix_en      = (k % c.div) == 0;
        o.x           = 10'(xx);
        o.y           = 10'(yy);
        o.hsync       = (xx >= c.ha + c.hfp && xx < c.ha + c.hfp + c.hs) ? c.pol[0] : !c.pol[0];
        o.vsync       = (yy >= c.va + c.vfp && yy < c.va + c.vfp + c.vs) ? c.pol[0] : !c.pol[0];
        o.blank_b     = (xx < c.ha) && (yy < c.va);
        o.frame_start = (xx == 0) && (yy == 0);
        o.line_start  = (xx == 0);
        o.in_board    = (xx >= c.bx) && (xx < c.bx + c.tx * c.tw) &&
                        (yy >= c.by) && (yy < c.by + c.ty * c.th);
        if (o.in_board) begin
            o.tc  = 8'((xx - c.bx) / c.tw);
            o.tr  = 8'((yy - c.by) / c.th);
            o.tpx = 8'((xx - c.bx) % c.tw);
            o.tpy = 8'((yy - c.by) % c.th);
        end
        return o;
    endfunction

    obs_t oa, ob;

    // Gather each DUT's outputs into one comparable word.
    always_comb begin
        oa             = '0;
        oa.pix_en      = ia.pix_en;
        oa.hsync       = ia.hsync;
        oa.vsync       = ia.vsync;
        oa.sync_b      = ia.sync_b;
        oa.blank_b     = ia.blank_b;
        oa.x           = ia.x;
        oa.y           = ia.y;
        oa.frame_start = ia.frame_start;
        oa.line_start  = ia.line_start;
        oa.in_board    = ia.in_board;
        oa.tc          = 8'(ia.tile_col);
        oa.tr          = 8'(ia.tile_row);
        oa.tpx         = 8'(ia.tile_px);
        oa.tpy         = 8'(ia.tile_py);
        ob             = '0;
        ob.pix_en      = ib.pix_en;
        ob.hsync       = ib.hsync;
        ob.vsync       = ib.vsync;
        ob.sync_b      = ib.sync_b;
        ob.blank_b     = ib.blank_b;
        ob.x           = 10'(ib.x);
        ob.y           = 10'(ib.y);
        ob.frame_start = ib.frame_start;
        ob.line_start  = ib.line_start;
        ob.in_board    = ib.in_board;
        ob.tc          = 8'(ib.tile_col);
        ob.tr          = 8'(ib.tile_row);
        ob.tpx         = 8'(ib.tile_px);
        ob.tpy         = 8'(ib.tile_py);
    end

    // Per-cycle comparison of both DUTs against the model.
    int k = 0;
    always begin
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else     k++;
        check_obs("obs_a", oa, model(CFG_A, k));
        check_obs("obs_b", ob, model(CFG_B, k));
    end

    initial begin
        int cyc, first_low, low_cnt, strobes, fs_prev, period, zeros, hmask, col4;

        // Reset held: literal reset values.
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_int("rst_pix_en", ia.pix_en, 0);
        check_int("rst_hsync", ia.hsync, 1);
        check_int("rst_vsync", ia.vsync, 1);
        check_int("rst_blank_b", ia.blank_b, 0);
        check_int("rst_x", ia.x, 0);
        check_int("rst_b_hsync", ib.hsync, 0);

        // First strobe after release.
        rst = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!ia.pix_en && cyc < 20);
        check_int("first_pix_latency", cyc, 2);
        check_int("first_x", ia.x, 0);
        check_int("first_y", ia.y, 0);
        check_int("first_frame_start", ia.frame_start, 1);
        check_int("first_blank_b", ia.blank_b, 1);
        check_int("first_in_board", ia.in_board, 0);

        // Walk line 0 of the default instance.
        first_low = -1; low_cnt = 0; strobes = 0; cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (ia.pix_en) begin
                strobes++;
                if (ia.y == 0) begin
                    if (!ia.hsync) begin
                        if (first_low < 0) first_low = int'(ia.x);
                        low_cnt++;
                    end
                    case (ia.x)
                        10'd80: begin
                            check_int("x80_in_board", ia.in_board, 1);
                            check_int("x80_tile_col", ia.tile_col, 0);
                            check_int("x80_tile_px", ia.tile_px, 0);
                        end
                        10'd140: begin
                            check_int("x140_tile_col", ia.tile_col, 1);
                            check_int("x140_tile_px", ia.tile_px, 0);
                        end
                        10'd559: begin
                            check_int("x559_tile_col", ia.tile_col, 7);
                            check_int("x559_tile_px", ia.tile_px, 59);
                            check_int("x559_tile_row", ia.tile_row, 0);
                        end
                        10'd560: begin
                            check_int("x560_in_board", ia.in_board, 0);
                            check_int("x560_tile_col", ia.tile_col, 0);
                            check_int("x560_tile_px", ia.tile_px, 0);
                        end
                        10'd639: check_int("x639_blank_b", ia.blank_b, 1);
                        10'd640: check_int("x640_blank_b", ia.blank_b, 0);
                        default: ;
                    endcase
                end
            end
        end while (!(ia.pix_en && ia.line_start && ia.y == 1) && cyc < 4000);
        check_int("line_strobes", strobes, 800);
        check_int("line1_x", ia.x, 0);
        check_int("line1_y", ia.y, 1);
        check_int("hsync_first_x", first_low, 656);
        check_int("hsync_width", low_cnt, 96);

        // Reset in the middle of an hsync pulse.
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!(ia.pix_en && ia.x == 700 && ia.y == 1) && cyc < 4000);
        check_int("x700_reached", cyc < 4000 ? 1 : 0, 1);
        check_int("x700_hsync", ia.hsync, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_int("midrst_hsync", ia.hsync, 1);
        check_int("midrst_pix_en", ia.pix_en, 0);
        check_int("midrst_x", ia.x, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!ia.pix_en && cyc < 20);
        check_int("restart_latency", cyc, 2);
        check_int("restart_frame_start", ia.frame_start, 1);
        check_int("restart_x", ia.x, 0);
        check_int("restart_y", ia.y, 0);

        // Alternate instance: 14x7 raster, one pixel per clk.
        fs_prev = -1; period = -1; zeros = 0; hmask = 0; col4 = -1;
        for (int i = 0; i < 220; i++) begin
            @(posedge clk); #1;
            if (!ib.pix_en) zeros++;
            if (ib.frame_start) begin
                if (fs_prev >= 0 && period < 0) period = i - fs_prev;
                fs_prev = i;
            end
            if (ib.y == 0 && ib.hsync) hmask |= (1 << ib.x);
            if (ib.y == 0 && ib.x == 4) col4 = int'(ib.tile_col);
        end
        check_int("b_pix_en_gaps", zeros, 0);
        check_int("b_frame_period", period, 98);
        check_int("b_hsync_mask", hmask, 'h0C00);
        check_int("b_x4_tile_col", col4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
